calc_core_fsm: RTL

//  Calculator datapath + control FSM instantiated by the calculator top level; sits directly downstream of the switch/button inputs.

---
 rtl/calc_core_fsm.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/calc_core_fsm.sv
// Calculator control FSM and datapath: sequences A/B/opcode entry on Confirm pulses,
// then computes add, sub, iterative shift-add multiply or repeated-subtraction divide.
module calc_core_fsm #(
  parameter int WIDTH = 8
) (
  input  logic               board_clk,
  input  logic               Reset,
  input  logic               Confirm,
  input  logic [WIDTH-1:0]   In,
  input  logic [1:0]         OpSel,
  output logic [WIDTH-1:0]   A,
  output logic [WIDTH-1:0]   B,
  output logic [2*WIDTH-1:0] Result,
  output logic [WIDTH-1:0]   Remainder,
  output logic               Neg,
  output logic [9:0]         Flags
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [3:0] QI      = 4'd0;
  localparam logic [3:0] QGET_A  = 4'd1;
  localparam logic [3:0] QGET_B  = 4'd2;
  localparam logic [3:0] QGET_OP = 4'd3;
  localparam logic [3:0] QADD    = 4'd4;
  localparam logic [3:0] QSUB    = 4'd5;
  localparam logic [3:0] QMUL    = 4'd6;
  localparam logic [3:0] QDIV    = 4'd7;
  localparam logic [3:0] QERR    = 4'd8;
  localparam logic [3:0] QDONE   = 4'd9;

  logic [3:0]         state;
  logic [CW-1:0]      mul_cnt;
  logic [WIDTH:0]     diff;
  logic [2*WIDTH-1:0] a_ext;
  logic [2*WIDTH-1:0] b_ext;

  // A-B carried one bit wider so the borrow doubles as the sign for extension.
  assign diff  = {1'b0, A} - {1'b0, B};
  assign a_ext = {{WIDTH{1'b0}}, A};
  assign b_ext = {{WIDTH{1'b0}}, B};

  always_ff @(posedge board_clk or posedge Reset) begin
    if (Reset) begin
      state     <= QI;
      A         <= '0;
      B         <= '0;
      Result    <= '0;
      Remainder <= '0;
      Neg       <= 1'b0;
      mul_cnt   <= '0;
    end else begin
      case (state)
        QI: begin
          A         <= '0;
          B         <= '0;
          Result    <= '0;
          Remainder <= '0;
          Neg       <= 1'b0;
          mul_cnt   <= '0;
          if (Confirm) state <= QGET_A;
        end
        QGET_A: begin
          if (Confirm) begin
            A     <= In;
            state <= QGET_B;
          end
        end
        QGET_B: begin
          if (Confirm) begin
            B     <= In;
            state <= QGET_OP;
          end
        end
        QGET_OP: begin
          if (Confirm) begin
            Result    <= '0;
            Remainder <= '0;
            Neg       <= 1'b0;
            mul_cnt   <= '0;
            case (OpSel)
              2'b00: state <= QADD;
              2'b01: state <= QSUB;
              2'b10: state <= QMUL;
              default: begin
                // Divide-by-zero is caught here on the already latched B.
                if (B != '0) begin
                  Remainder <= A;
                  state     <= QDIV;
                end else begin
                  state <= QERR;
                end
              end
            endcase
          end
        end
        QADD: begin
          Result <= a_ext + b_ext;
          state  <= QDONE;
        end
        QSUB: begin
          Result <= {{(WIDTH-1){diff[WIDTH]}}, diff};
          Neg    <= (A < B);
          state  <= QDONE;
        end
        QMUL: begin
          if (B[mul_cnt]) Result <= Result + (a_ext << mul_cnt);
          if (mul_cnt == CW'(WIDTH-1)) begin
            state <= QDONE;
          end else begin
            mul_cnt <= mul_cnt + 1'b1;
          end
        end
        QDIV: begin
          if (Remainder >= B) begin
            Remainder <= Remainder - B;
            Result    <= Result + 1'b1;
          end else begin
            state <= QDONE;
          end
        end
        QERR: begin
          Result <= '0;
          if (Confirm) state <= QI;
        end
        QDONE: begin
          if (Confirm) state <= QI;
        end
        default: state <= QI;
      endcase
    end
  end

  // Illegal encodings decode as QI so the LEDs stay one-hot until recovery.
  always_comb begin
    Flags = 10'b1000000000;
    case (state)
      QGET_A:  Flags = 10'b0100000000;
      QGET_B:  Flags = 10'b0010000000;
      QGET_OP: Flags = 10'b0001000000;
      QADD:    Flags = 10'b0000100000;
      QSUB:    Flags = 10'b0000010000;
      QMUL:    Flags = 10'b0000001000;
      QDIV:    Flags = 10'b0000000100;
      QERR:    Flags = 10'b0000000010;
      QDONE:   Flags = 10'b0000000001;
      default: Flags = 10'b1000000000;
    endcase
  end

endmodule
